// File: rtl/keypad_pkg.sv
// Purpose : shared types and constants for the keypad entry block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    localparam int NUM_W = 13;

    localparam logic [3:0] KEY_CLR = 4'hE;  // '*'
    localparam logic [3:0] KEY_BSP = 4'hF;  // '#'

    // Frame result: MSB set means the frame had no pressed key, else [3:0] is the code.
    localparam logic [4:0] FRAME_NONE = 5'b1_0000;

    // Row-major layout, entry i = code of key at index r*4+c, stored at [i*4 +: 4].
    localparam logic [63:0] KEY_LAYOUT = {
        4'hD, 4'hF, 4'h0, 4'hE,   // row 3: * 0 # D
        4'hC, 4'h9, 4'h8, 4'h7,   // row 2: 7 8 9 C
        4'hB, 4'h6, 4'h5, 4'h4,   // row 1: 4 5 6 B
        4'hA, 4'h3, 4'h2, 4'h1    // row 0: 1 2 3 A
    };

    function automatic logic [3:0] key_code_of(input logic [3:0] idx);
        return KEY_LAYOUT[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Purpose : keypad pins plus decoded-entry outputs bundled as one port.
// Latency : n/a (wires only).
// Backpressure: none; all outputs are fire-and-forget.
// master = keypad_entry side, slave = board / consumer side.
interface keypad_if;
    import keypad_pkg::*;

    logic [3:0]       row;        // active-low rows, asynchronous to clk
    logic [3:0]       col;        // one-hot-low column drive
    logic [NUM_W-1:0] num;        // accumulated decimal entry
    logic             key_valid;  // 1-cycle accept pulse
    logic [3:0]       key_code;   // last accepted key
    logic             overflow;   // 1-cycle digit-rejected pulse

    modport master (input row, output col, num, key_valid, key_code, overflow);
    modport slave  (output row, input col, num, key_valid, key_code, overflow);
endinterface

// File: rtl/keypad_scanner.sv
// Purpose : column scan, row synchroniser and per-frame lowest-index key decode.
// Latency : frame_done/frame_key valid in the last cycle of column 3's slot.
// Backpressure: none; the scan free-runs and never stalls.
// Ports: clk, rst, row (async in), col (drive out), frame_done (1-cycle), frame_key (5-bit).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       frame_done,
    output logic [4:0] frame_key
);
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    row_meta_q, row_sync_q;
    logic [15:0]   hits_q, hits_d;
    logic [15:0]   hits_now;
    logic          slot_end;

    always_comb begin
        slot_end  = (presc_q == PW'(SCAN_DIV - 1));
        presc_d   = slot_end ? '0 : presc_q + PW'(1);
        col_idx_d = slot_end ? col_idx_q + 2'd1 : col_idx_q;
        // Rotate the low bit left so the drive is registered straight to the pins.
        col_d     = slot_end ? {col_q[2:0], col_q[3]} : col_q;

        // Current column's rows merged into the frame map; used at slot end.
        hits_now = hits_q;
        for (int r = 0; r < 4; r++) begin
            hits_now[r*4 + int'(col_idx_q)] = ~row_sync_q[r];
        end
        hits_d = slot_end ? hits_now : hits_q;

        frame_done = slot_end && (col_idx_q == 2'd3);

        // Descending scan so the lowest pressed index wins.
        frame_key = FRAME_NONE;
        for (int i = 15; i >= 0; i--) begin
            if (hits_now[i]) frame_key = {1'b0, key_code_of(4'(i))};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
            hits_q     <= '0;
        end else begin
            presc_q    <= presc_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            hits_q     <= hits_d;
        end
    end

    assign col = col_q;

endmodule

// File: rtl/keypad_entry.sv
// Purpose : debounced 4x4 keypad to decimal number accumulator.
// Latency : key_valid/num/overflow update one cycle after the frame-end sample edge.
// Backpressure: none; outputs are pulses, scanning is never stalled.
// Ports: clk, rst (async active-high), kp (keypad_if.master: row in; col, num, key_valid, key_code, overflow out).
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 25000,
    parameter int DEBOUNCE_FRAMES = 10,
    parameter int MAX_VALUE       = 8191
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    logic       frame_done;
    logic [4:0] frame_key;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clk        (clk),
        .rst        (rst),
        .row        (kp.row),
        .col        (kp.col),
        .frame_done (frame_done),
        .frame_key  (frame_key)
    );

    kp_state_e        state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0]    rel_q, rel_d, rel_inc;
    logic [NUM_W-1:0] num_q, num_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             overflow_q, overflow_d;

    logic             accept;
    logic [3:0]       acc_code;
    logic [16:0]      num_ext;
    logic             key_none;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        rel_d       = rel_q;
        num_d       = num_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        overflow_d  = 1'b0;
        accept      = 1'b0;
        acc_code    = cand_q;
        key_none    = frame_key[4];
        cnt_inc     = cnt_q + CW'(1);
        rel_inc     = rel_q + CW'(1);

        if (frame_done) begin
            case (state_q)
                IDLE: begin
                    if (!key_none) begin
                        cand_d = frame_key[3:0];
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            accept   = 1'b1;
                            acc_code = frame_key[3:0];
                            rel_d    = '0;
                            state_d  = HELD;
                        end else begin
                            state_d  = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (key_none) begin
                        state_d = IDLE;
                    end else if (frame_key[3:0] == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_FRAMES)) begin
                            accept  = 1'b1;
                            rel_d   = '0;
                            state_d = HELD;
                        end
                    end else begin
                        cand_d = frame_key[3:0];
                        cnt_d  = CW'(1);
                    end
                end
                HELD: begin
                    if (key_none) begin
                        if (rel_inc == CW'(DEBOUNCE_FRAMES)) begin
                            rel_d   = '0;
                            state_d = IDLE;
                        end else begin
                            rel_d   = rel_inc;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // 17 bits holds 8191*10+9 without wrap.
        num_ext = 17'(num_q) * 17'd10 + 17'(acc_code);

        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = acc_code;
            if (is_digit(acc_code)) begin
                if (num_ext <= 17'(MAX_VALUE)) num_d = num_ext[NUM_W-1:0];
                else                          overflow_d = 1'b1;
            end else if (acc_code == KEY_CLR) begin
                num_d = '0;
            end else if (acc_code == KEY_BSP) begin
                num_d = num_q / NUM_W'(10);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            rel_q       <= '0;
            num_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            num_q       <= num_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            overflow_q  <= overflow_d;
        end
    end

    assign kp.num       = num_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Purpose : randomized + directed bench for keypad_entry with a queue scoreboard.
// Latency : expects each accept one cycle after the frame that completes it.
// Backpressure: none modelled; the keypad matrix is a pure function of col and pressed keys.
module tb_keypad_entry;
    localparam int SCAN_DIV = 4;
    localparam int DF       = 3;
    localparam int MAXV     = 8191;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_if kp();

    keypad_entry #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DF),
        .MAX_VALUE       (MAXV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // Matrix model: row r pulled low when key (r,c) is pressed and column c driven low.
    logic [15:0] pressed = 16'h0000;
    always_comb begin
        kp.row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int code;
        int num;
        int ovf;
    } exp_t;
    exp_t exp_q[$];

    int layout[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    // Reference: a key is accepted when the last DF frame results are that same key
    // while armed; after an accept, DF consecutive empty frames re-arm.
    int hist[$];
    bit armed;
    int mnum;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frame_result(input logic [15:0] p);
        for (int i = 0; i < 16; i++) if (p[i]) return layout[i];
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        armed = 1'b1;
        mnum  = 0;
    endtask

    task automatic model_accept(input int code);
        exp_t e;
        int v;
        e.code = code;
        e.ovf  = 0;
        if (code <= 9) begin
            v = mnum * 10 + code;
            if (v <= MAXV) mnum = v;
            else           e.ovf = 1;
        end else if (code == 14) begin
            mnum = 0;
        end else if (code == 15) begin
            mnum = mnum / 10;
        end
        e.num = mnum;
        exp_q.push_back(e);
    endtask

    task automatic model_frame(input int res);
        bit same;
        hist.push_back(res);
        if (hist.size() > DF) void'(hist.pop_front());
        if (hist.size() == DF) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
            if (same && armed && hist[0] >= 0) begin
                armed = 1'b0;
                model_accept(hist[0]);
            end else if (same && !armed && hist[0] < 0) begin
                armed = 1'b1;
            end
        end
    endtask

    // One frame of stimulus; entered and left #1 after a frame boundary edge.
    task automatic run_frame(input logic [15:0] p);
        logic [3:0] ec;
        pressed = p;
        for (int s = 0; s < 4; s++) begin
            ec = ~(4'b0001 << s);
            check("col", int'(kp.col), int'(ec));
            repeat (SCAN_DIV) @(posedge clk);
            #1;
        end
        model_frame(frame_result(p));
    endtask

    task automatic hold(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) run_frame(p);
    endtask

    task automatic tap(input int idx);
        logic [15:0] m;
        m = 16'h0001 << idx;
        hold(m, DF);
        hold(16'h0000, DF);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_col", int'(kp.col), 4'b1110);
        check("rst_num", int'(kp.num), 0);
        check("rst_key_valid", int'(kp.key_valid), 0);
        check("rst_overflow", int'(kp.overflow), 0);
        check("rst_key_code", int'(kp.key_code), 0);
        rst = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (kp.key_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_key_valid: got code %0d num %0d, expected no pulse at %0t",
                             kp.key_code, kp.num, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("key_code", int'(kp.key_code), e.code);
                    check("num", int'(kp.num), e.num);
                    check("overflow", int'(kp.overflow), e.ovf);
                end
            end else if (kp.overflow) begin
                checks++;
                errors++;
                $display("FAIL stray_overflow: got 1 without key_valid, expected 0 at %0t", $time);
            end
        end
    end

    initial begin
        logic [15:0] m;
        int kind;
        #2 rst = 1'b1;

        // 1: reset state and column rotation (checked inside every frame).
        do_reset();
        hold(16'h0000, 2);

        // 2: hold '5' for 15 frames, one accept.
        hold(16'h0001 << 5, 15);
        hold(16'h0000, DF + 1);
        check("s2_num", int'(kp.num), 5);

        // 3: bounce on '7'.
        do_reset();
        hold(16'h0001 << 8, 1);
        hold(16'h0000, 1);
        hold(16'h0001 << 8, 3);
        hold(16'h0000, 3);
        check("s3_num", int'(kp.num), 7);

        // 4: 8,1,9,1 then overflow, backspace, clear.
        do_reset();
        tap(9); tap(0); tap(10); tap(0);
        check("s4_num_8191", int'(kp.num), 8191);
        tap(1);
        check("s4_num_ovf", int'(kp.num), 8191);
        tap(14);
        check("s4_num_bsp", int'(kp.num), 819);
        tap(12);
        check("s4_num_clr", int'(kp.num), 0);

        // 5: '1' and '9' together, lowest index wins.
        hold((16'h0001 << 0) | (16'h0001 << 10), DF);
        hold(16'h0000, DF);
        check("s5_num", int'(kp.num), 1);

        // 6: reset during frame 2 of a '4' press, key kept held.
        run_frame(16'h0001 << 4);
        repeat (8) @(posedge clk);
        do_reset();
        hold(16'h0001 << 4, DF);
        hold(16'h0000, DF);
        check("s6_num", int'(kp.num), 4);

        // Randomized runs of empty / single / double presses.
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 3);
            m = 16'h0000;
            if (kind >= 1) m[$urandom_range(0, 15)] = 1'b1;
            if (kind == 3) m[$urandom_range(0, 15)] = 1'b1;
            hold(m, $urandom_range(1, 4));
        end
        hold(16'h0000, DF + 1);
        check("rand_num", int'(kp.num), mnum);
        check("pending_events", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
